// File: rtl/dmem_arbiter_if.sv
// Data-memory arbitration bus: CPU MEM-stage port, debug/loader port and memory side.
// The slave modport is the arbiter's view; master is the surrounding system.
interface dmem_arbiter_if #(
    parameter int unsigned DM_ADDRESS = 9,
    parameter int unsigned DATA_W     = 32
);
    logic                  cpu_rd;
    logic                  cpu_wr;
    logic [DM_ADDRESS-1:0] cpu_addr;
    logic [DATA_W-1:0]     cpu_wdata;
    logic [2:0]            cpu_func3;
    logic                  cpu_halted;
    logic                  cpu_stall;
    logic [DATA_W-1:0]     cpu_rdata;

    logic                  dbg_req;
    logic                  dbg_we;
    logic                  dbg_last;
    logic [DM_ADDRESS-1:0] dbg_addr;
    logic [DATA_W-1:0]     dbg_wdata;
    logic                  dbg_gnt;
    logic                  dbg_rvalid;
    logic [DATA_W-1:0]     dbg_rdata;

    logic                  mem_rd;
    logic                  mem_wr;
    logic [DM_ADDRESS-1:0] mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [2:0]            mem_func3;
    logic [DATA_W-1:0]     mem_rdata;

    modport slave (
        input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata, cpu_func3, cpu_halted,
        output cpu_stall, cpu_rdata,
        input  dbg_req, dbg_we, dbg_last, dbg_addr, dbg_wdata,
        output dbg_gnt, dbg_rvalid, dbg_rdata,
        output mem_rd, mem_wr, mem_addr, mem_wdata, mem_func3,
        input  mem_rdata
    );

    modport master (
        output cpu_rd, cpu_wr, cpu_addr, cpu_wdata, cpu_func3, cpu_halted,
        input  cpu_stall, cpu_rdata,
        output dbg_req, dbg_we, dbg_last, dbg_addr, dbg_wdata,
        input  dbg_gnt, dbg_rvalid, dbg_rdata,
        input  mem_rd, mem_wr, mem_addr, mem_wdata, mem_func3,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: CPU priority, starvation-bounded debug access,
// locked debug bursts capped at BURST_MAX beats, halted core yields to debug.
module dmem_arbiter #(
    parameter int unsigned DM_ADDRESS = 9,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 8,
    parameter int unsigned BURST_MAX  = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    dmem_arbiter_if.slave bus
);
    localparam int unsigned SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam int unsigned BW = $clog2(BURST_MAX + 1);
    localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);
    localparam logic [BW-1:0] BURST_TOP  = BW'(BURST_MAX);

    typedef enum logic {CPU_OWN, DBG_OWN} state_e;

    state_e            state_q, state_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic [BW-1:0]     beat_q, beat_d;
    logic              rvalid_q, rvalid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic          cpu_req;
    logic          dbg_take;
    logic          serve_dbg;
    logic          serve_cpu;
    logic          gnt;
    logic          stall;
    logic          dbg_accept;
    logic [BW-1:0] beat_inc;

    assign cpu_req  = bus.cpu_rd | bus.cpu_wr;
    assign dbg_take = bus.dbg_req &&
                      (!cpu_req || bus.cpu_halted || (starve_q == STARVE_TOP));
    assign beat_inc = beat_q + BW'(1);

    always_comb begin
        state_d   = state_q;
        starve_d  = starve_q;
        beat_d    = beat_q;
        serve_dbg = 1'b0;
        serve_cpu = 1'b0;
        gnt       = 1'b0;
        stall     = 1'b0;
        unique case (state_q)
            CPU_OWN: begin
                if (dbg_take) begin
                    serve_dbg = 1'b1;
                    gnt       = 1'b1;
                    stall     = cpu_req;
                    starve_d  = '0;
                    if (!bus.dbg_last && (BURST_MAX > 1)) begin
                        state_d = DBG_OWN;
                        beat_d  = BW'(1);
                    end
                end else begin
                    serve_cpu = 1'b1;
                    if (cpu_req && bus.dbg_req) begin
                        if (starve_q != STARVE_TOP) starve_d = starve_q + SW'(1);
                    end else if (!bus.dbg_req) begin
                        starve_d = '0;
                    end
                end
            end
            DBG_OWN: begin
                stall = cpu_req;
                gnt   = bus.dbg_req;
                // A missing beat releases the lock; the CPU only regains the bus next cycle.
                if (bus.dbg_req) begin
                    serve_dbg = 1'b1;
                    beat_d    = beat_inc;
                    if (bus.dbg_last || (beat_inc == BURST_TOP)) begin
                        state_d = CPU_OWN;
                        beat_d  = '0;
                    end
                end else begin
                    state_d = CPU_OWN;
                    beat_d  = '0;
                end
            end
            default: state_d = CPU_OWN;
        endcase
    end

    // Strobes and grant are masked while reset is held so nothing reaches memory.
    assign bus.mem_rd    = rst_ni & (serve_dbg ? !bus.dbg_we : (serve_cpu & bus.cpu_rd));
    assign bus.mem_wr    = rst_ni & (serve_dbg ?  bus.dbg_we : (serve_cpu & bus.cpu_wr));
    assign bus.mem_addr  = serve_dbg ? bus.dbg_addr  : bus.cpu_addr;
    assign bus.mem_wdata = serve_dbg ? bus.dbg_wdata : bus.cpu_wdata;
    assign bus.mem_func3 = serve_dbg ? 3'b010        : bus.cpu_func3;

    assign bus.dbg_gnt    = rst_ni & gnt;
    assign bus.cpu_stall  = stall;
    assign bus.cpu_rdata  = bus.mem_rdata;
    assign bus.dbg_rvalid = rvalid_q;
    assign bus.dbg_rdata  = rdata_q;

    assign dbg_accept = bus.dbg_req && bus.dbg_gnt;

    always_comb begin
        rvalid_d = dbg_accept && !bus.dbg_we;
        rdata_d  = rdata_q;
        if (dbg_accept && !bus.dbg_we) rdata_d = bus.mem_rdata;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= CPU_OWN;
            starve_q <= '0;
            beat_q   <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            beat_q   <= beat_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: combinational grant/stall checks inline,
// debug read responses matched against a scoreboard queue by a monitor.
module tb_dmem_arbiter;
    logic clk;
    logic rst_n;

    dmem_arbiter_if #(.DM_ADDRESS(9), .DATA_W(32)) bus ();

    dmem_arbiter #(
        .DM_ADDRESS(9),
        .DATA_W    (32),
        .STARVE_MAX(8),
        .BURST_MAX (4)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    logic [31:0] mem [128];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Simple word-addressed memory with combinational read.
    assign bus.mem_rdata = mem[bus.mem_addr[8:2]];
    always @(posedge clk) begin
        if (bus.mem_wr) mem[bus.mem_addr[8:2]] <= bus.mem_wdata;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.dbg_rvalid) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL rvalid_unexpected: got rdata %h expected no response", bus.dbg_rdata);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (bus.dbg_rdata !== e) begin
                    failures++;
                    $display("FAIL dbg_rdata: got %h expected %h", bus.dbg_rdata, e);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cpu(input logic rd, input logic wr, input logic [8:0] a, input logic [31:0] d);
        bus.cpu_rd    = rd;
        bus.cpu_wr    = wr;
        bus.cpu_addr  = a;
        bus.cpu_wdata = d;
        bus.cpu_func3 = 3'b010;
    endtask

    task automatic set_dbg(input logic req, input logic we, input logic last,
                           input logic [8:0] a, input logic [31:0] d);
        bus.dbg_req   = req;
        bus.dbg_we    = we;
        bus.dbg_last  = last;
        bus.dbg_addr  = a;
        bus.dbg_wdata = d;
    endtask

    // Counts cycles until dbg_gnt rises (inputs held), bounded.
    task automatic wait_gnt(input int exp_wait, input string nm);
        int n = 0;
        while (!bus.dbg_gnt && n < 40) begin
            n++;
            cyc();
            #1;
        end
        chk(nm, 32'(n), 32'(exp_wait));
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = '0;
        rst_n = 1'b0;
        bus.cpu_halted = 1'b0;
        set_cpu(1'b0, 1'b1, 9'h010, 32'h1111_1111);
        set_dbg(1'b1, 1'b0, 1'b1, 9'h010, 32'h0);
        #12;
        chk("rst_mem_wr", 32'(bus.mem_wr), 32'd0);
        chk("rst_gnt", 32'(bus.dbg_gnt), 32'd0);
        chk("rst_rvalid", 32'(bus.dbg_rvalid), 32'd0);
        chk("rst_rdata", bus.dbg_rdata, 32'h0);
        set_cpu(1'b0, 1'b0, 9'h000, 32'h0);
        set_dbg(1'b0, 1'b0, 1'b0, 9'h000, 32'h0);
        cyc();
        rst_n = 1'b1;

        // Idle CPU store
        cyc();
        set_cpu(1'b0, 1'b1, 9'h010, 32'hDEAD_BEEF);
        #1;
        chk("st_mem_wr", 32'(bus.mem_wr), 32'd1);
        chk("st_mem_rd", 32'(bus.mem_rd), 32'd0);
        chk("st_stall", 32'(bus.cpu_stall), 32'd0);
        chk("st_gnt", 32'(bus.dbg_gnt), 32'd0);
        chk("st_addr", 32'(bus.mem_addr), 32'h010);
        chk("st_wdata", bus.mem_wdata, 32'hDEAD_BEEF);

        // Debug read on a free slot
        cyc();
        set_cpu(1'b0, 1'b0, 9'h000, 32'h0);
        set_dbg(1'b1, 1'b0, 1'b1, 9'h010, 32'h0);
        #1;
        chk("free_gnt", 32'(bus.dbg_gnt), 32'd1);
        chk("free_mem_rd", 32'(bus.mem_rd), 32'd1);
        chk("free_func3", 32'(bus.mem_func3), 32'd2);
        exp_q.push_back(32'hDEAD_BEEF);
        cyc();
        set_dbg(1'b0, 1'b0, 1'b0, 9'h000, 32'h0);

        // Starvation: CPU reads continuously, debug write held
        cyc();
        set_cpu(1'b1, 1'b0, 9'h020, 32'h0);
        set_dbg(1'b1, 1'b1, 1'b1, 9'h030, 32'h1234_5678);
        #1;
        for (int c = 1; c <= 8; c++) begin
            chk($sformatf("starve_gnt_c%0d", c), 32'(bus.dbg_gnt), 32'd0);
            chk($sformatf("starve_rd_c%0d", c), 32'(bus.mem_rd), 32'd1);
            cyc();
            #1;
        end
        chk("starve_c9_gnt", 32'(bus.dbg_gnt), 32'd1);
        chk("starve_c9_stall", 32'(bus.cpu_stall), 32'd1);
        chk("starve_c9_wr", 32'(bus.mem_wr), 32'd1);
        chk("starve_c9_addr", 32'(bus.mem_addr), 32'h030);
        cyc();
        #1;
        chk("starve_c10_stall", 32'(bus.cpu_stall), 32'd0);
        chk("starve_c10_gnt", 32'(bus.dbg_gnt), 32'd0);
        chk("starve_c10_rd", 32'(bus.mem_rd), 32'd1);
        cyc();
        set_dbg(1'b0, 1'b0, 1'b0, 9'h000, 32'h0);

        // Burst cap: 6-beat write burst against a busy CPU
        cyc();
        set_dbg(1'b1, 1'b1, 1'b0, 9'h040, 32'hB000_0001);
        #1;
        wait_gnt(8, "burst_b1_wait");
        chk("burst_b1_stall", 32'(bus.cpu_stall), 32'd1);
        for (int b = 2; b <= 4; b++) begin
            cyc();
            set_dbg(1'b1, 1'b1, 1'b0, 9'(9'h040 + 4 * (b - 1)), 32'hB000_0000 + 32'(b));
            #1;
            chk($sformatf("burst_b%0d_gnt", b), 32'(bus.dbg_gnt), 32'd1);
            chk($sformatf("burst_b%0d_stall", b), 32'(bus.cpu_stall), 32'd1);
            chk($sformatf("burst_b%0d_addr", b), 32'(bus.mem_addr), 32'h040 + 32'(4 * (b - 1)));
        end
        cyc();
        set_dbg(1'b1, 1'b1, 1'b0, 9'h050, 32'hB000_0005);
        #1;
        chk("burst_rel_gnt", 32'(bus.dbg_gnt), 32'd0);
        chk("burst_rel_stall", 32'(bus.cpu_stall), 32'd0);
        chk("burst_rel_rd", 32'(bus.mem_rd), 32'd1);
        wait_gnt(8, "burst_b5_wait");
        chk("burst_b5_stall", 32'(bus.cpu_stall), 32'd1);
        cyc();
        set_dbg(1'b1, 1'b1, 1'b1, 9'h054, 32'hB000_0006);
        #1;
        chk("burst_b6_gnt", 32'(bus.dbg_gnt), 32'd1);
        chk("burst_b6_stall", 32'(bus.cpu_stall), 32'd1);
        cyc();
        set_dbg(1'b0, 1'b0, 1'b0, 9'h000, 32'h0);
        #1;
        chk("burst_end_stall", 32'(bus.cpu_stall), 32'd0);

        // Early release
        cyc();
        set_cpu(1'b0, 1'b0, 9'h020, 32'h0);
        set_dbg(1'b1, 1'b1, 1'b0, 9'h060, 32'hAAAA_0001);
        #1;
        chk("early_b1_gnt", 32'(bus.dbg_gnt), 32'd1);
        cyc();
        set_cpu(1'b1, 1'b0, 9'h020, 32'h0);
        set_dbg(1'b0, 1'b0, 1'b0, 9'h000, 32'h0);
        #1;
        chk("early_drop_stall", 32'(bus.cpu_stall), 32'd1);
        chk("early_drop_rd", 32'(bus.mem_rd), 32'd0);
        chk("early_drop_wr", 32'(bus.mem_wr), 32'd0);
        cyc();
        #1;
        chk("early_next_stall", 32'(bus.cpu_stall), 32'd0);
        chk("early_next_rd", 32'(bus.mem_rd), 32'd1);

        // Halted core: debug wins immediately, back-to-back reads
        cyc();
        bus.cpu_halted = 1'b1;
        set_dbg(1'b1, 1'b0, 1'b1, 9'h040, 32'h0);
        #1;
        chk("halt_gnt", 32'(bus.dbg_gnt), 32'd1);
        chk("halt_stall", 32'(bus.cpu_stall), 32'd1);
        chk("halt_addr", 32'(bus.mem_addr), 32'h040);
        chk("halt_cpu_rdata", bus.cpu_rdata, 32'hB000_0001);
        exp_q.push_back(32'hB000_0001);
        cyc();
        set_dbg(1'b1, 1'b0, 1'b1, 9'h04C, 32'h0);
        #1;
        chk("halt_r2_gnt", 32'(bus.dbg_gnt), 32'd1);
        exp_q.push_back(32'hB000_0004);
        cyc();
        set_dbg(1'b1, 1'b0, 1'b1, 9'h054, 32'h0);
        exp_q.push_back(32'hB000_0006);
        cyc();
        set_dbg(1'b1, 1'b0, 1'b1, 9'h030, 32'h0);
        exp_q.push_back(32'h1234_5678);
        cyc();
        set_dbg(1'b1, 1'b0, 1'b1, 9'h060, 32'h0);
        exp_q.push_back(32'hAAAA_0001);
        cyc();
        bus.cpu_halted = 1'b0;
        set_cpu(1'b0, 1'b0, 9'h000, 32'h0);
        set_dbg(1'b0, 1'b0, 1'b0, 9'h000, 32'h0);
        cyc();
        cyc();
        #1;
        chk("rdata_hold", bus.dbg_rdata, 32'hAAAA_0001);

        // Reset during a locked read burst
        cyc();
        set_dbg(1'b1, 1'b0, 1'b0, 9'h060, 32'h0);
        #1;
        chk("rb_b1_gnt", 32'(bus.dbg_gnt), 32'd1);
        cyc();
        rst_n = 1'b0;
        set_cpu(1'b1, 1'b0, 9'h020, 32'h0);
        #1;
        chk("rb_rvalid", 32'(bus.dbg_rvalid), 32'd0);
        chk("rb_rdata", bus.dbg_rdata, 32'h0);
        chk("rb_mem_rd", 32'(bus.mem_rd), 32'd0);
        chk("rb_mem_wr", 32'(bus.mem_wr), 32'd0);
        chk("rb_gnt", 32'(bus.dbg_gnt), 32'd0);
        cyc();
        cyc();
        rst_n = 1'b1;
        #1;
        chk("rb_post_gnt", 32'(bus.dbg_gnt), 32'd0);
        chk("rb_post_stall", 32'(bus.cpu_stall), 32'd0);
        chk("rb_post_rd", 32'(bus.mem_rd), 32'd1);
        cyc();
        set_cpu(1'b0, 1'b0, 9'h000, 32'h0);
        set_dbg(1'b0, 1'b0, 1'b0, 9'h000, 32'h0);
        cyc();
        cyc();
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single data memory between the pipeline's MEM stage and a debug/loader port. The CPU has priority by default. A starvation counter guarantees the debug port forward progress, and a halted core yields the memory unconditionally. Debug accesses may be locked bursts of up to BURST_MAX beats. `cpu_stall` freezes the pipeline whenever the CPU's MEM-stage access cannot be served in the current cycle.

## Interface
- DM_ADDRESS, 9, data memory byte address width
- DATA_W, 32, data width
- STARVE_MAX, 8, consecutive cycles the debug port may be denied while requesting; 0 means the debug port always preempts
- BURST_MAX, 4, maximum beats in one locked debug burst (≥1)

- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- cpu_rd  in  1  MEM-stage read request
- cpu_wr  in  1  MEM-stage write request
- cpu_addr  in  DM_ADDRESS  MEM-stage address
- cpu_wdata  in  DATA_W  MEM-stage store data
- cpu_func3  in  3  MEM-stage access size/sign
- cpu_halted  in  1  core halted; debug gets absolute priority
- cpu_stall  out  1  combinational; CPU access not served this cycle, so the pipeline holds
- cpu_rdata  out  DATA_W  combinational passthrough of mem_rdata
- dbg_req  in  1  debug beat valid
- dbg_we  in  1  debug beat is a write
- dbg_last  in  1  last beat of the debug burst
- dbg_addr  in  DM_ADDRESS  debug address
- dbg_wdata  in  DATA_W  debug write data
- dbg_gnt  out  1  combinational; a beat is accepted when dbg_req && dbg_gnt
- dbg_rvalid  out  1  registered; pulses the cycle after an accepted read beat
- dbg_rdata  out  DATA_W  registered read data; holds its value between reads
- mem_rd, mem_wr  out  1  memory strobes
- mem_addr  out  DM_ADDRESS  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_func3  out  3  access size; debug beats use 3'b010 (word)
- mem_rdata  in  DATA_W  memory read data, combinational and valid in the same cycle as mem_rd

## Operation
- Definition: cpu_req = cpu_rd | cpu_wr.
- Two-state FSM: CPU_OWN (reset state) and DBG_OWN.
- starve_cnt is $clog2(STARVE_MAX+1) bits and saturates. beat_cnt is $clog2(BURST_MAX+1) bits.

**CPU_OWN**
- The debug port takes the memory this cycle when dbg_take = dbg_req && (!cpu_req || cpu_halted || starve_cnt==STARVE_MAX).
- When dbg_take is high:
  - Memory is driven from the debug fields; dbg_gnt=1; cpu_stall=cpu_req.
  - starve_cnt←0.
  - If !dbg_last && BURST_MAX>1, go to DBG_OWN with beat_cnt←1. Otherwise stay in CPU_OWN.
- Otherwise:
  - Memory is driven from the CPU fields: mem_rd=cpu_rd, mem_wr=cpu_wr. dbg_gnt=0; cpu_stall=0.
  - If cpu_req && dbg_req, starve_cnt←starve_cnt+1 (saturating). If !dbg_req, starve_cnt←0.

**DBG_OWN**
- cpu_stall=cpu_req every cycle in this state. dbg_gnt=dbg_req.
- When dbg_req is high, the beat is served: beat_cnt←beat_cnt+1. Return to CPU_OWN if dbg_last or beat_cnt+1==BURST_MAX.
- When dbg_req is low, no memory access occurs, the lock is released, and the FSM returns to CPU_OWN.

**Common rules**
- When nothing is served, mem_rd=mem_wr=0 while mem_addr, mem_wdata and mem_func3 carry the CPU fields.
- CPU read/write are never both asserted; if they are, both strobes pass through unchanged.
- An accepted debug read captures mem_rdata into dbg_rdata and sets dbg_rvalid for exactly one cycle. An accepted debug write leaves dbg_rvalid low.
- A stalled CPU keeps its request stable; the arbiter does not latch CPU fields.

## Timing
- Zero-cycle grant: memory strobes, dbg_gnt and cpu_stall are combinational from current inputs and state.
- The debug read response has 1-cycle latency (dbg_rvalid and dbg_rdata are registered).
- Back-to-back debug reads give dbg_rvalid high on consecutive cycles.
- Worst-case debug wait while the CPU requests continuously is STARVE_MAX cycles. The beat is granted on cycle STARVE_MAX+1.
- Worst-case CPU stall is BURST_MAX consecutive cycles per debug burst. After a burst, starve_cnt is 0, so the CPU is guaranteed at least STARVE_MAX served cycles before the next preemption.
- Reset values (asynchronous, reset low):
  - State CPU_OWN; starve_cnt=0; beat_cnt=0; dbg_rvalid=0; dbg_rdata=0.
  - Combinational outputs then follow the CPU_OWN rules.
- Reset asserted mid-burst aborts the burst and drops any pending dbg_rvalid. No memory strobe is issued while reset is low.
- cpu_halted rising during DBG_OWN has no effect. Falling during a burst does not end the burst.

## Test plan
- **Idle after reset:** CPU store (addr 0x010, data 0xDEADBEEF, func3 3'b010) with no debug request → mem_wr=1, cpu_stall=0, dbg_gnt=0.
- **Debug read on a free slot:** dbg_req read of 0x010 with cpu_req=0 → dbg_gnt=1 the same cycle; next cycle dbg_rvalid=1 and dbg_rdata=0xDEADBEEF.
- **Starvation:** STARVE_MAX=8, CPU requesting continuously, dbg_req held → dbg_gnt=0 for 8 cycles; on cycle 9 dbg_gnt=1 and cpu_stall=1; cycle 10 CPU is served again.
- **Burst cap:** BURST_MAX=4, 6-beat write burst with dbg_last on beat 6, CPU requesting → cpu_stall=1 for beats 1–4; the lock releases after beat 4; beats 5–6 are granted later.
- **Early release and halt:** dbg_req drops mid-burst → return to CPU_OWN that cycle with cpu_stall=0 next cycle. With cpu_halted=1 and both requesting → debug is granted immediately at starve_cnt=0.
- **Reset in burst:** reset pulled low in DBG_OWN after a read beat → dbg_rvalid=0 and mem strobes 0 immediately; state is CPU_OWN after reset is released.
